// File: rtl/unified_mem_arbiter.sv
// Arbitrates a single-ported fixed-latency memory between instruction fetch and data ports.
// Data wins by default; a saturating starve counter forces fetch through after STARVE_MAX losses.
`timescale 1ns/1ps
module unified_mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    input  logic                i_if_flush,
    output logic                o_if_gnt,
    output logic                o_if_rvalid,
    output logic [DATA_W-1:0]   o_if_rdata,
    input  logic                i_d_req,
    input  logic                i_d_we,
    input  logic [ADDR_W-1:0]   i_d_addr,
    input  logic [DATA_W-1:0]   i_d_wdata,
    input  logic [DATA_W/8-1:0] i_d_be,
    output logic                o_d_gnt,
    output logic                o_d_rvalid,
    output logic [DATA_W-1:0]   o_d_rdata,
    output logic                o_m_en,
    output logic                o_m_we,
    output logic [ADDR_W-1:0]   o_m_addr,
    output logic [DATA_W-1:0]   o_m_wdata,
    output logic [DATA_W/8-1:0] o_m_be,
    input  logic [DATA_W-1:0]   i_m_rdata,
    output logic                o_stall_if,
    output logic                o_stall_mem
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

    typedef enum logic {StIdle, StBusy} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_own_if;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_flushed;
    logic [STV_W-1:0]    r_starve;
    logic                r_m_en;
    logic                r_m_we;
    logic [ADDR_W-1:0]   r_m_addr;
    logic [DATA_W-1:0]   r_m_wdata;
    logic [BE_W-1:0]     r_m_be;
    logic                r_if_rvalid;
    logic [DATA_W-1:0]   r_if_rdata;
    logic                r_d_rvalid;
    logic [DATA_W-1:0]   r_d_rdata;

    logic w_idle, w_busy, w_if_cand, w_if_force, w_if_gnt, w_d_gnt, w_done, w_flushed_now;

    assign w_idle        = (r_state == StIdle);
    assign w_busy        = (r_state == StBusy);
    assign w_if_cand     = i_if_req & ~i_if_flush;
    assign w_if_force    = (r_starve == STV_W'(STARVE_MAX));
    assign w_if_gnt      = ~i_rst & w_idle & w_if_cand & (~i_d_req | w_if_force);
    assign w_d_gnt       = ~i_rst & w_idle & i_d_req & ~(w_if_cand & w_if_force);
    assign w_done        = w_busy & (r_cnt == CNT_W'(MEM_LAT - 1));
    assign w_flushed_now = r_flushed | i_if_flush;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:  if (w_if_gnt | w_d_gnt) w_state_nxt = StBusy;
            StBusy:  if (w_done) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_own_if    <= 1'b0;
            r_cnt       <= '0;
            r_flushed   <= 1'b0;
            r_starve    <= '0;
            r_m_en      <= 1'b0;
            r_m_we      <= 1'b0;
            r_m_addr    <= '0;
            r_m_wdata   <= '0;
            r_m_be      <= '0;
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rvalid  <= 1'b0;
            r_d_rdata   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_m_en  <= w_if_gnt | w_d_gnt;
            if (w_if_gnt | w_d_gnt) begin
                r_own_if  <= w_if_gnt;
                r_cnt     <= '0;
                r_flushed <= 1'b0;
                r_m_addr  <= w_if_gnt ? i_if_addr : i_d_addr;
                r_m_we    <= w_d_gnt & i_d_we;
                r_m_wdata <= w_d_gnt ? i_d_wdata : '0;
                r_m_be    <= (w_d_gnt & i_d_we) ? i_d_be : {BE_W{1'b1}};
            end else if (w_busy) begin
                if (!w_done) r_cnt <= r_cnt + CNT_W'(1);
                if (r_own_if && i_if_flush) r_flushed <= 1'b1;
            end
            // A flush in the final BUSY cycle still has to kill the response.
            r_if_rvalid <= w_done & r_own_if & ~w_flushed_now;
            r_d_rvalid  <= w_done & ~r_own_if;
            if (w_done && r_own_if) r_if_rdata <= i_m_rdata;
            if (w_done && !r_own_if) r_d_rdata <= r_m_we ? '0 : i_m_rdata;
            if (w_if_gnt) begin
                r_starve <= '0;
            end else if (w_idle && w_if_cand && w_d_gnt && !w_if_force) begin
                r_starve <= r_starve + STV_W'(1);
            end
        end
    end

    assign o_if_gnt    = w_if_gnt;
    assign o_d_gnt     = w_d_gnt;
    assign o_if_rvalid = r_if_rvalid & ~i_if_flush;
    assign o_if_rdata  = r_if_rdata;
    assign o_d_rvalid  = r_d_rvalid;
    assign o_d_rdata   = r_d_rdata;
    assign o_m_en      = r_m_en;
    assign o_m_we      = r_m_we;
    assign o_m_addr    = r_m_addr;
    assign o_m_wdata   = r_m_wdata;
    assign o_m_be      = r_m_be;

    // Stalls cover the grant cycle too: the data only arrives MEM_LAT+1 cycles later.
    assign o_stall_if  = (i_if_req & ~o_if_rvalid) | (w_busy & r_own_if & ~w_flushed_now);
    assign o_stall_mem = (i_d_req & ~o_d_rvalid) | (w_busy & ~r_own_if);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: fetch, data priority, starvation, stores, flush, reset.
`timescale 1ns/1ps
module tb_unified_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be, m_be;
    logic        m_en, m_we, stall_if, stall_mem;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [31:0] mem_addr_q;
    logic [139:0] outs;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
        .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata), .i_d_be(d_be),
        .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
        .o_m_en(m_en), .o_m_we(m_we), .o_m_addr(m_addr), .o_m_wdata(m_wdata), .o_m_be(m_be),
        .i_m_rdata(m_rdata), .o_stall_if(stall_if), .o_stall_mem(stall_mem)
    );

    // Memory model: address latched on m_en, data valid from the following cycle.
    always @(posedge clk) if (m_en) mem_addr_q <= m_addr;
    always_comb begin
        if (mem_addr_q == 32'h10)      m_rdata = 32'h0050_0093;
        else if (mem_addr_q == 32'h18) m_rdata = 32'hDEAD_BEEF;
        else                           m_rdata = mem_addr_q ^ 32'hA5A5_0000;
    end

    assign outs = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, m_en, m_we,
                   m_addr, m_wdata, m_be, stall_if, stall_mem};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 0; if_flush = 0; if_addr = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        repeat (2) tick();
        #1;
        n_chk++; if (outs !== '0) begin n_fail++; $display("FAIL reset_outs got=%h exp=0", outs); end
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        tick(); if_req = 1; if_addr = 32'h10; #1;
        n_chk++; if ({if_gnt, d_gnt, stall_if, m_en} !== 4'b1010) begin n_fail++; $display("FAIL fetch_c1 got=%b exp=1010", {if_gnt, d_gnt, stall_if, m_en}); end
        tick(); if_req = 0; #1;
        n_chk++; if ({m_en, m_we, m_be, stall_if, if_gnt} !== 8'b10_1111_10) begin n_fail++; $display("FAIL fetch_c2_cmd got=%b exp=10111110", {m_en, m_we, m_be, stall_if, if_gnt}); end
        n_chk++; if (m_addr !== 32'h10) begin n_fail++; $display("FAIL fetch_c2_addr got=%h exp=10", m_addr); end
        tick(); #1;
        n_chk++; if ({m_en, stall_if, if_rvalid} !== 3'b010) begin n_fail++; $display("FAIL fetch_c3 got=%b exp=010", {m_en, stall_if, if_rvalid}); end
        tick(); #1;
        n_chk++; if ({if_rvalid, stall_if, d_rvalid} !== 3'b100) begin n_fail++; $display("FAIL fetch_c4 got=%b exp=100", {if_rvalid, stall_if, d_rvalid}); end
        n_chk++; if (if_rdata !== 32'h0050_0093) begin n_fail++; $display("FAIL fetch_rdata got=%h exp=00500093", if_rdata); end
        tick(); #1;
        n_chk++; if (if_rvalid !== 1'b0) begin n_fail++; $display("FAIL fetch_c5_rvalid got=%b exp=0", if_rvalid); end
    endtask

    task automatic test_simultaneous();
        tick(); if_req = 1; if_addr = 32'h10; d_req = 1; d_we = 0; d_addr = 32'h18; #1;
        n_chk++; if ({d_gnt, if_gnt, stall_if, stall_mem} !== 4'b1011) begin n_fail++; $display("FAIL sim_c1 got=%b exp=1011", {d_gnt, if_gnt, stall_if, stall_mem}); end
        tick(); d_req = 0; #1;
        n_chk++; if ({m_en, m_we, m_be, stall_if, stall_mem} !== 8'b10_1111_11) begin n_fail++; $display("FAIL sim_c2 got=%b exp=10111111", {m_en, m_we, m_be, stall_if, stall_mem}); end
        n_chk++; if (m_addr !== 32'h18) begin n_fail++; $display("FAIL sim_c2_addr got=%h exp=18", m_addr); end
        tick(); #1;
        n_chk++; if ({stall_if, if_gnt, d_rvalid} !== 3'b100) begin n_fail++; $display("FAIL sim_c3 got=%b exp=100", {stall_if, if_gnt, d_rvalid}); end
        tick(); #1;
        n_chk++; if ({d_rvalid, if_gnt, stall_if, stall_mem} !== 4'b1110) begin n_fail++; $display("FAIL sim_c4 got=%b exp=1110", {d_rvalid, if_gnt, stall_if, stall_mem}); end
        n_chk++; if (d_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sim_d_rdata got=%h exp=deadbeef", d_rdata); end
        tick(); if_req = 0; #1;
        n_chk++; if ({m_en, stall_if} !== 2'b11 || m_addr !== 32'h10) begin n_fail++; $display("FAIL sim_c5 got=%b addr=%h exp=11 addr=10", {m_en, stall_if}, m_addr); end
        tick(); #1;
        n_chk++; if (stall_if !== 1'b1) begin n_fail++; $display("FAIL sim_c6_stall got=%b exp=1", stall_if); end
        tick(); #1;
        n_chk++; if ({if_rvalid, stall_if} !== 2'b10 || if_rdata !== 32'h0050_0093) begin n_fail++; $display("FAIL sim_c7 got=%b data=%h exp=10 data=00500093", {if_rvalid, stall_if}, if_rdata); end
    endtask

    task automatic test_starvation();
        tick(); d_req = 1; d_we = 0; d_addr = 32'h20; if_req = 1; if_addr = 32'h14;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) repeat (3) tick();
            #1;
            n_chk++; if ({d_gnt, if_gnt} !== ((k == 4) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL starve_arb%0d got=%b exp=%b", k, {d_gnt, if_gnt}, (k == 4) ? 2'b01 : 2'b10); end
            n_chk++; if ({d_rvalid, if_rvalid} !== {(k >= 1 && k != 5), (k == 5)}) begin n_fail++; $display("FAIL starve_rv%0d got=%b exp=%b", k, {d_rvalid, if_rvalid}, {(k >= 1 && k != 5), (k == 5)}); end
            if (k == 5) begin
                n_chk++; if (if_rdata !== 32'hA5A5_0014) begin n_fail++; $display("FAIL starve_if_rdata got=%h exp=a5a50014", if_rdata); end
            end
        end
        tick(); d_req = 0; if_req = 0;
        tick(); tick(); #1;
        n_chk++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hA5A5_0020) begin n_fail++; $display("FAIL starve_last_d got=%b data=%h exp=1 data=a5a50020", d_rvalid, d_rdata); end
    endtask

    task automatic test_store();
        tick(); d_req = 1; d_we = 1; d_addr = 32'h18; d_wdata = 32'h2A; d_be = 4'hF; #1;
        n_chk++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL store_gnt got=%b exp=1", d_gnt); end
        tick(); d_req = 0; d_we = 0; #1;
        n_chk++; if ({m_en, m_we, m_be} !== 6'b11_1111 || m_wdata !== 32'h2A || m_addr !== 32'h18) begin n_fail++; $display("FAIL store_cmd got=%b wd=%h a=%h exp=111111 wd=2a a=18", {m_en, m_we, m_be}, m_wdata, m_addr); end
        tick(); tick(); #1;
        n_chk++; if ({d_rvalid, if_rvalid} !== 2'b10 || d_rdata !== 32'h0) begin n_fail++; $display("FAIL store_done got=%b data=%h exp=10 data=0", {d_rvalid, if_rvalid}, d_rdata); end
        d_req = 1; d_we = 1; d_addr = 32'h1C; d_wdata = 32'h55; d_be = 4'h3; #1;
        n_chk++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL store2_gnt got=%b exp=1", d_gnt); end
        tick(); d_req = 0; d_we = 0; #1;
        n_chk++; if ({m_en, m_we, m_be} !== 6'b11_0011 || m_wdata !== 32'h55) begin n_fail++; $display("FAIL store2_cmd got=%b wd=%h exp=110011 wd=55", {m_en, m_we, m_be}, m_wdata); end
        tick(); tick(); #1;
        n_chk++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h0) begin n_fail++; $display("FAIL store2_done got=%b data=%h exp=1 data=0", d_rvalid, d_rdata); end
    endtask

    task automatic test_flush();
        tick(); if_req = 1; if_addr = 32'h10; #1;
        n_chk++; if (if_gnt !== 1'b1) begin n_fail++; $display("FAIL flush_gnt got=%b exp=1", if_gnt); end
        tick(); if_req = 0; if_flush = 1; #1;
        n_chk++; if (stall_if !== 1'b0) begin n_fail++; $display("FAIL flush_c2_stall got=%b exp=0", stall_if); end
        tick(); if_flush = 0; #1;
        n_chk++; if (stall_if !== 1'b0) begin n_fail++; $display("FAIL flush_c3_stall got=%b exp=0", stall_if); end
        tick(); if_req = 1; if_addr = 32'h14; #1;
        n_chk++; if ({if_rvalid, if_gnt} !== 2'b01) begin n_fail++; $display("FAIL flush_c4 got=%b exp=01", {if_rvalid, if_gnt}); end
        tick(); if_req = 0; tick(); tick(); #1;
        n_chk++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hA5A5_0014) begin n_fail++; $display("FAIL flush_refetch got=%b data=%h exp=1 data=a5a50014", if_rvalid, if_rdata); end
        tick(); if_req = 1; if_addr = 32'h10;
        tick(); if_req = 0; tick();
        tick(); if_flush = 1; #1;
        n_chk++; if ({if_rvalid, stall_if} !== 2'b00) begin n_fail++; $display("FAIL flush_rvcycle got=%b exp=00", {if_rvalid, stall_if}); end
        tick(); if_req = 1; #1;
        n_chk++; if ({if_gnt, if_rvalid} !== 2'b00) begin n_fail++; $display("FAIL flush_idle_block got=%b exp=00", {if_gnt, if_rvalid}); end
        tick(); if_req = 0; if_flush = 0; #1;
        n_chk++; if (m_en !== 1'b0) begin n_fail++; $display("FAIL flush_idle_men got=%b exp=0", m_en); end
        d_req = 1; d_we = 0; d_addr = 32'h18;
        tick(); d_req = 0; if_flush = 1;
        tick(); if_flush = 0;
        tick(); #1;
        n_chk++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL flush_d_unaffected got=%b data=%h exp=1 data=deadbeef", d_rvalid, d_rdata); end
    endtask

    task automatic test_reset_mid();
        tick(); d_req = 1; d_we = 0; d_addr = 32'h18; #1;
        n_chk++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL rstmid_gnt got=%b exp=1", d_gnt); end
        tick(); d_req = 0; rst = 1;
        tick(); rst = 0; #1;
        n_chk++; if (outs !== '0) begin n_fail++; $display("FAIL rstmid_c3_outs got=%h exp=0", outs); end
        tick(); #1;
        n_chk++; if ({d_rvalid, m_en} !== 2'b00) begin n_fail++; $display("FAIL rstmid_c4 got=%b exp=00", {d_rvalid, m_en}); end
        tick(); #1;
        n_chk++; if (outs !== '0) begin n_fail++; $display("FAIL rstmid_c5_outs got=%h exp=0", outs); end
        d_req = 1; d_addr = 32'h20; #1;
        n_chk++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL rstmid_regnt got=%b exp=1", d_gnt); end
        tick(); d_req = 0; tick(); tick(); #1;
        n_chk++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hA5A5_0020) begin n_fail++; $display("FAIL rstmid_reload got=%b data=%h exp=1 data=a5a50020", d_rvalid, d_rdata); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_simultaneous();
        test_starvation();
        test_store();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
